// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - normalize and round-to-nearest-even stage after the FP adder.
// Optional FPNR_FAST_SHIFT_EN: single-cycle LZC and barrel shift replaces the bit-serial SHIFT state.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_invalid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [26:0]       frac_q;

  logic              round_up;
  logic [24:0]       rsum;
  logic signed [9:0] exp_fin;
  logic [22:0]       mant;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Rounding works on frac[26:2] only, so a carry lands in rsum[24].
  always_comb begin
    round_up = frac_q[1] & (frac_q[0] | frac_q[2]);
    rsum     = frac_q[26:2] + {24'd0, round_up};
    exp_fin  = exp_q + $signed({9'd0, rsum[24]});
    mant     = rsum[24] ? rsum[23:1] : rsum[22:0];
  end

`ifdef FPNR_FAST_SHIFT_EN
  logic [4:0] lzc;

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (frac_q[i]) lzc = 5'(25 - i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      frac_q        <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q        <= in_sign;
            exp_q         <= $signed({2'b00, in_exp});
            frac_q        <= in_frac;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_invalid   <= 1'b0;
            if (in_exp == 8'h00 || in_exp == 8'hFF) begin
              out_result  <= 32'h7FC0_0000;
              out_invalid <= 1'b1;
              state       <= DONE;
            end else if (in_frac == 27'd0) begin
              out_result <= {in_sign, 31'd0};
              state      <= DONE;
            end else if (in_frac[26]) begin
              // Fold the dropped bit into sticky so rounding still sees it.
              frac_q <= {1'b0, in_frac[26:2], in_frac[1] | in_frac[0]};
              exp_q  <= $signed({2'b00, in_exp}) + 10'sd1;
              state  <= ROUND;
            end else if (in_frac[25]) begin
              state <= ROUND;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
`ifdef FPNR_FAST_SHIFT_EN
          if ($signed({5'd0, lzc}) >= exp_q) begin
            out_result    <= {sign_q, 31'd0};
            out_underflow <= 1'b1;
            state         <= DONE;
          end else begin
            frac_q <= frac_q << lzc;
            exp_q  <= exp_q - $signed({5'd0, lzc});
            state  <= ROUND;
          end
`else
          if (exp_q == 10'sd1) begin
            out_result    <= {sign_q, 31'd0};
            out_underflow <= 1'b1;
            state         <= DONE;
          end else begin
            frac_q <= {frac_q[25:0], 1'b0};
            exp_q  <= exp_q - 10'sd1;
            if (frac_q[24]) state <= ROUND;
          end
`endif
        end
        ROUND: begin
          if (exp_fin >= 10'sd255) begin
            out_result   <= {sign_q, 8'hFF, 23'd0};
            out_overflow <= 1'b1;
          end else begin
            out_result <= {sign_q, exp_fin[7:0], mant};
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Normalize-and-round stage that sits directly downstream of the floating-point adder datapath. It accepts the raw sign, biased exponent and unnormalized mantissa sum with guard/sticky bits, and normalizes it with a multi-cycle shift FSM. It then applies IEEE-754 round-to-nearest-even and produces a packed single-precision result with exception flags. The stage uses a valid/ready handshake on both sides and processes one operation at a time.

## Interface

- No parameters; widths are fixed to single precision.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream operation present
- in_ready  output  1  stage can accept; high only in IDLE
- in_sign  input  1  result sign
- in_exp  input  8  biased exponent of the larger operand; legal range 1..254
- in_frac  input  27  [26] carry-out, [25] hidden-bit position, [24:2] fraction, [1] guard, [0] sticky
- out_valid  output  1  result held; high only in DONE
- out_ready  input  1  downstream accepts result
- out_result  output  32  packed single-precision result
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero
- out_invalid  output  1  illegal input exponent

## Operation

- FSM states: IDLE, SHIFT, ROUND, DONE.
- Internal exponent is 10-bit signed, so no wrap occurs during adjustment.
- **IDLE:** in_ready=1. On in_valid&&in_ready, latch all inputs, clear all flags, and branch:
  - in_exp==0 or 255: result 0x7FC00000, out_invalid=1, go to DONE.
  - in_frac==0: result {in_sign,31'b0}, go to DONE.
  - in_frac[26]=1: shift right 1 with new bit0 = old bit1|old bit0, exp+1, go to ROUND.
  - in_frac[26:25]==01: go to ROUND.
  - Otherwise: go to SHIFT.
- **SHIFT:** each cycle, shift left 1, exp−1. Shifting stops when bit25=1, then go to ROUND.
  - If exp would reach 0 before normalization: result {sign,31'b0}, out_underflow=1, go to DONE.
- **ROUND:**
  - Round up when guard && (sticky || frac[2]); add 1 at bit 2.
  - If the round-up carries into bit 26: shift right 1, exp+1.
  - If the final exp ≥ 255: result {sign,8'hFF,23'b0}, out_overflow=1.
  - Otherwise: result {sign, exp[7:0], frac[24:2]}.
  - Go to DONE.
- **DONE:** out_valid=1. out_result and flags are held stable until out_ready=1, then go to IDLE.
- in_ready is combinational from state only. No back-to-back accept occurs in the DONE→IDLE cycle.

## Timing

- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, and all flags=0. Any in-flight operation is discarded.
- Let N be the accept cycle. out_valid rises at:
  - N+1 for zero or invalid input
  - N+2 for input already normalized or with carry-out
  - N+2+k for k left shifts (k≤25)
- Underflow exits SHIFT on the cycle the exponent would hit 0. out_valid rises the following cycle.
- The result holds indefinitely under out_ready=0.
- in_valid is ignored outside IDLE.

## Configuration

- FPNR_FAST_SHIFT_EN
  - **Defined:** SHIFT lasts exactly one cycle, using a leading-zero count of in_frac[25:0] and a single barrel shift. If the count ≥ exp, the result underflows to zero. out_valid rises at N+3 for any k≥1.
  - **Undefined:** one-bit-per-cycle shifting as described above. No barrel shifter is synthesized.
  - Results and flags are bit-identical in both modes; only latency differs.

## Test plan

- Carry-out: in_exp=127, in_frac=27'h4000000 → out_result=0x40000000 (2.0), no flags, out_valid at N+2.
- Cancellation: in_exp=127, in_frac=27'h0800000 → 0x3E800000 (0.25). out_valid at N+4, or N+3 with FPNR_FAST_SHIFT_EN.
- Rounding:
  - in_exp=127, in_frac=27'h3FFFFFE → round-up carry gives 0x40000000.
  - in_frac=27'h2000002 (tie, even LSB) → 0x3F800000.
- Exceptions:
  - in_exp=254, in_frac=27'h4000000 → 0x7F800000 with out_overflow=1.
  - in_exp=2, in_frac=27'h0000100 → 0x00000000 with out_underflow=1.
  - in_exp=255 → 0x7FC00000 with out_invalid=1.
- Zero: in_sign=1, in_frac=0 → 0x80000000 at N+1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → out_result is stable and in_ready=0.
  - Assert rst_n=0 mid-SHIFT → out_valid=0 and in_ready=1 immediately.
  - A following operation completes correctly.
